mem_bus_master: RTL
===================

// Module: mem_bus_master
// PURPOSE
//  Bus initiator for the shared 6502 memory bus (address/data/read_en) that mem responds to.
//  Bulk-loads a byte stream into mem (WRITE) or dumps a mem region to a byte stream (READ).
//  Used for program load and memory inspection while the chip is held off the bus.
//  Upstream/downstream byte streams use valid/ready handshakes.
// PARAMETERS
//  ADDR_W    16  bus address width
//  DATA_W    8   bus data width
//  RD_LAT    1   ph1 cycles from address-valid (read_en=1) to mem data valid; >=1
// PORTS
//  ph1        in     1       single clock; all state on rising edge
//  reset      in     1       asynchronous, active-low reset
//  start      in     1       begin a transfer (sampled in IDLE only)
//  mode       in     1       0 = WRITE (stream->mem), 1 = READ (mem->stream)
//  base_addr  in     ADDR_W  first bus address, latched on start
//  length     in     ADDR_W  byte count, latched on start; 0 = no transfer
//  in_valid   in     1       write-stream byte available
//  in_data    in     DATA_W  write-stream byte
//  in_ready   out    1       byte accepted when in_valid & in_ready
//  out_valid  out    1       read-stream byte available
//  out_data   out    DATA_W  read-stream byte
//  out_ready  in     1       consumer accepts when out_valid & out_ready
//  address    out    ADDR_W  bus address
//  data       inout  DATA_W  bus data; driven only in W_DRIVE, else 'z
//  read_en    out    1       1 = read/idle, 0 = write strobe
//  busy       out    1       high in any state except IDLE
//  done       out    1       one-cycle pulse at transfer end
//  checksum   out    DATA_W  running checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset (any time, incl. mid-transfer): state=IDLE, address=0, read_en=1, data='z,
//   in_ready=0, out_valid=0, out_data=0, busy=0, done=0, checksum=0; no partial write completes.
//  States: IDLE, W_WAIT, W_DRIVE, R_ADDR, R_WAIT, R_OUT, FIN.
//  IDLE: start=1 -> latch base_addr/length into addr/remaining; length==0 -> FIN;
//   else mode0 -> W_WAIT, mode1 -> R_ADDR. start ignored outside IDLE.
//  W_WAIT: in_ready=1, read_en=1. On in_valid: capture in_data -> W_DRIVE.
//  W_DRIVE: exactly one cycle; read_en=0, data=captured byte, address=addr.
//   Then addr+=1, remaining-=1; remaining hits 0 -> FIN else W_WAIT.
//   Max write throughput: one byte per 2 cycles.
//  R_ADDR: address=addr, read_en=1, load latency counter=RD_LAT-1 -> R_WAIT.
//  R_WAIT: count down; at 0 sample data into out_data -> R_OUT.
//  R_OUT: out_valid=1, out_data stable until out_ready; on handshake addr+=1,
//   remaining-=1; remaining 0 -> FIN else R_ADDR. Bus address held stable throughout.
//  FIN: done=1 for one cycle, busy=1 -> IDLE.
//  address wraps 16'hFFFF -> 16'h0000; length up to 16'hFFFF honoured exactly.
//  read_en never low outside W_DRIVE; data never driven while read_en=1.
//  in_ready and out_valid never simultaneously high.
// CONFIGURATION
//  MEM_BUS_MASTER_CHECKSUM_EN defined: checksum = 8-bit modulo-256 sum of every byte
//   transferred (written or read) since last start; cleared on start; valid from done.
//  Undefined: checksum tied to 0, no adder logic.
// TESTING
//  1 reset low mid W_DRIVE -> read_en=1, data='z same cycle; busy=0; mem unchanged at that addr.
//  2 WRITE base=16'h0200 len=3 bytes A9,01,00 (in_valid always 1) -> mem[0200..0202]=A9,01,00;
//    read_en low exactly 3 cycles; done pulses 1 cycle; checksum=8'hAA if CHECKSUM_EN.
//  3 READ base=16'h0200 len=3, out_ready toggling 1/0 -> stream A9,01,00, no drops/dups,
//    out_data stable while stalled.
//  4 WRITE base=16'hFFFF len=2 (11,22) -> mem[FFFF]=11, mem[0000]=22 (wrap).
//  5 start with len=0 -> done pulse 2 cycles after start, no bus activity, in_ready stays 0.
//  6 start pulsed while busy -> ignored; in-flight transfer completes unchanged.

Source files
------------

// File: rtl/mem_bus_master.sv
// Bus initiator that bulk-writes a byte stream into mem or dumps a mem region.
// Optional running checksum enabled by defining MEM_BUS_MASTER_CHECKSUM_EN.
module mem_bus_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              read_en,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_DRIVE,
        R_ADDR,
        R_WAIT,
        R_OUT,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] wbyte_q, wbyte_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [LW-1:0]     lat_q, lat_d;

    // Bus and stream outputs are pure decodes of the current state
    assign address   = addr_q;
    assign read_en   = (state_q != W_DRIVE);
    assign data      = (state_q == W_DRIVE) ? wbyte_q : 'z;
    assign in_ready  = (state_q == W_WAIT);
    assign out_valid = (state_q == R_OUT);
    assign out_data  = rdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

    // State and datapath registers
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wbyte_q <= '0;
            rdata_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wbyte_q <= wbyte_d;
            rdata_q <= rdata_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state and datapath update for the transfer sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wbyte_d = wbyte_q;
        rdata_d = rdata_q;
        lat_d   = lat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = length;
                    if (length == '0) state_d = FIN;
                    else if (mode)    state_d = R_ADDR;
                    else              state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (in_valid) begin
                    wbyte_d = in_data;
                    state_d = W_DRIVE;
                end
            end
            W_DRIVE: begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == 1) ? FIN : W_WAIT;
            end
            R_ADDR: begin
                lat_d   = LW'(RD_LAT - 1);
                state_d = R_WAIT;
            end
            R_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d = data;
                    state_d = R_OUT;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            R_OUT: begin
                if (out_ready) begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == 1) ? FIN : R_ADDR;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_BUS_MASTER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Modulo-256 sum of every byte moved since the last accepted start
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (state_q == IDLE && start) begin
            sum_q <= '0;
        end else if (state_q == W_DRIVE) begin
            sum_q <= sum_q + wbyte_q;
        end else if (state_q == R_OUT && out_ready) begin
            sum_q <= sum_q + rdata_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule
